analog_status_poller: RTL

APB master that periodically scans the analog status register array and keeps a shadow copy of each status word. It reads the enabled channels in ascending order, one APB read per channel, once per programmed period. It raises sticky interrupts on a status change or a bus error. It sits between the analog status slave and the SoC control logic, so software and other blocks read the shadows instead of issuing APB reads.

---
 rtl/analog_status_poller_if.sv | 24 ++
 rtl/analog_status_poller.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/analog_status_poller_if.sv
// APB connection between the analog status poller (master) and the analog status slave.
interface analog_status_poller_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic [3:0]        PSTRB;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/analog_status_poller.sv
// Periodic APB read-only scanner that keeps a shadow copy of each analog status word.
// Define ANALOG_POLL_TIMEOUT_EN to add a 255-cycle PREADY watchdog on each access.
module analog_status_poller #(
  parameter int              NUM_CH    = 4,
  parameter int              ADDR_W    = 16,
  parameter int              PERIOD_W  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [PERIOD_W-1:0]   period,
  input  logic [NUM_CH-1:0]     ch_mask,
  input  logic                  irq_clear,
  analog_status_poller_if.master apb,
  output logic [NUM_CH*32-1:0]  shadow_data,
  output logic [NUM_CH-1:0]     shadow_valid,
  output logic                  change_irq,
  output logic                  err_irq,
  output logic [$clog2(NUM_CH)-1:0] err_ch,
  output logic                  busy,
  output logic                  scan_done
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, GAP} state_t;

  state_t              state;
  logic [CH_W-1:0]     ch_idx;
  logic [PERIOD_W-1:0] timer;
  logic [CH_W:0]       first_sel;
  logic [CH_W:0]       next_sel;
  logic                xfer_done;
  logic                xfer_ok;
  logic                timed_out;

  // MSB flags that a masked channel at or above 'from' exists; low bits give the lowest one.
  function automatic logic [CH_W:0] pick_ch(input logic [NUM_CH-1:0] mask, input int from);
    logic [CH_W:0] sel;
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (i >= from && mask[i]) sel = {1'b1, CH_W'(i)};
    return sel;
  endfunction

  function automatic logic [ADDR_W-1:0] ch_addr(input logic [CH_W-1:0] ch);
    return BASE_ADDR + (ADDR_W'(ch) << 2);
  endfunction

  assign first_sel = pick_ch(ch_mask, 0);
  assign next_sel  = pick_ch(ch_mask, int'(ch_idx) + 1);

`ifdef ANALOG_POLL_TIMEOUT_EN
  logic [7:0] wd_cnt;
  assign timed_out = (state == ACCESS) && !apb.PREADY && (wd_cnt == 8'd254);
`else
  assign timed_out = 1'b0;
`endif

  assign xfer_done = (state == ACCESS) && (apb.PREADY || timed_out);
  assign xfer_ok   = apb.PREADY && !apb.PSLVERR;

  assign apb.PWRITE = 1'b0;
  assign apb.PWDATA = '0;
  assign apb.PSTRB  = '0;

  // The timer loads period-1 so scan start decisions are exactly 'period' cycles apart.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ch_idx       <= '0;
      timer        <= '0;
      apb.PADDR    <= '0;
      apb.PSEL     <= 1'b0;
      apb.PENABLE  <= 1'b0;
      shadow_data  <= '0;
      shadow_valid <= '0;
      change_irq   <= 1'b0;
      err_irq      <= 1'b0;
      err_ch       <= '0;
      busy         <= 1'b0;
      scan_done    <= 1'b0;
`ifdef ANALOG_POLL_TIMEOUT_EN
      wd_cnt       <= '0;
`endif
    end else begin
      scan_done <= 1'b0;
      if (timer != '0) timer <= timer - PERIOD_W'(1);
      if (irq_clear) begin
        change_irq <= 1'b0;
        err_irq    <= 1'b0;
        err_ch     <= '0;
      end
      case (state)
        IDLE: begin
          if (enable && timer == '0) begin
            timer <= (period == '0) ? '0 : period - PERIOD_W'(1);
            if (first_sel[CH_W]) begin
              ch_idx    <= first_sel[CH_W-1:0];
              apb.PADDR <= ch_addr(first_sel[CH_W-1:0]);
              apb.PSEL  <= 1'b1;
              busy      <= 1'b1;
              state     <= SETUP;
            end else begin
              scan_done <= 1'b1;
            end
          end
        end
        SETUP: begin
          apb.PENABLE <= 1'b1;
          state       <= ACCESS;
`ifdef ANALOG_POLL_TIMEOUT_EN
          wd_cnt      <= '0;
`endif
        end
        ACCESS: begin
`ifdef ANALOG_POLL_TIMEOUT_EN
          if (!apb.PREADY) wd_cnt <= wd_cnt + 8'd1;
`endif
          if (xfer_done) begin
            if (xfer_ok) begin
              if (shadow_valid[ch_idx] && shadow_data[{ch_idx, 5'd0} +: 32] != apb.PRDATA)
                change_irq <= 1'b1;
              shadow_data[{ch_idx, 5'd0} +: 32] <= apb.PRDATA;
              shadow_valid[ch_idx]              <= 1'b1;
            end else begin
              err_irq <= 1'b1;
              err_ch  <= ch_idx;
            end
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            if (enable) begin
              state <= GAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              timer <= '0;
            end
          end
        end
        GAP: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
            timer <= '0;
          end else if (next_sel[CH_W]) begin
            ch_idx    <= next_sel[CH_W-1:0];
            apb.PADDR <= ch_addr(next_sel[CH_W-1:0]);
            apb.PSEL  <= 1'b1;
            state     <= SETUP;
          end else begin
            state     <= IDLE;
            busy      <= 1'b0;
            scan_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
